// File: rtl/mmips_pkg.sv
// Shared types for the mmips memory path: owner and arbiter state encodings
// plus the default address/data widths.
package mmips_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LDR = 1'b1
    } owner_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker: bit 0 is the CPU, bit 1 the loader. The pointer
// remembers the last winner and only moves when the caller commits a grant.
module rr_arb2
    import mmips_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    owner_e last_q;
    owner_e last_d;

    // Pick the requester that did not win last time; a lone requester always wins.
    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        if (req[0] && (!req[1] || (last_q == OWN_LDR))) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end else begin
            gnt = 2'b00;
        end
        if (advance && gnt[0]) begin
            last_d = OWN_CPU;
        end else if (advance && gnt[1]) begin
            last_d = OWN_LDR;
        end else begin
            last_d = last_q;
        end
    end

    // Last-winner pointer; resets to the loader so the CPU wins first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= OWN_LDR;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the CPU and the loader/debug port: one
// transaction in flight, fixed read latency, done pulse and CPU stall.
module mem_arbiter
    import mmips_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_done,
    output logic [DATA_W-1:0] ldr_rdata,
    input  logic              ldr_lock,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int               CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MEM_LAT);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              we_q, we_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
    logic [1:0]        arb_req_s;
    logic [1:0]        arb_gnt_s;
    logic              issue_s;
    logic              done_s;

    assign arb_req_s = {ldr_req, cpu_req & ~ldr_lock};

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req_s),
        .advance (issue_s),
        .gnt     (arb_gnt_s)
    );

    // Next-state, memory mux and done generation; reset blocks grants and done.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        ldr_rdata_d = ldr_rdata_q;
        issue_s     = 1'b0;
        done_s      = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = {ADDR_W{1'b0}};
        mem_wdata   = {DATA_W{1'b0}};
        cpu_gnt     = 1'b0;
        ldr_gnt     = 1'b0;
        cpu_done    = 1'b0;
        ldr_done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rst && (arb_gnt_s != 2'b00)) begin
                    issue_s = 1'b1;
                    mem_en  = 1'b1;
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(1);
                    if (arb_gnt_s[1]) begin
                        owner_d   = OWN_LDR;
                        ldr_gnt   = 1'b1;
                        mem_we    = ldr_we;
                        mem_addr  = ldr_addr;
                        mem_wdata = ldr_wdata;
                        we_d      = ldr_we;
                    end else begin
                        owner_d   = OWN_CPU;
                        cpu_gnt   = 1'b1;
                        mem_we    = cpu_we;
                        mem_addr  = cpu_addr;
                        mem_wdata = cpu_wdata;
                        we_d      = cpu_we;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == LAT_C) begin
                    done_s  = !rst;
                    state_d = ST_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                    if (owner_q == OWN_LDR) begin
                        ldr_done = done_s;
                        if (done_s && !we_q) begin
                            ldr_rdata_d = mem_rdata;
                        end else begin
                            ldr_rdata_d = ldr_rdata_q;
                        end
                    end else begin
                        cpu_done = done_s;
                        if (done_s && !we_q) begin
                            cpu_rdata_d = mem_rdata;
                        end else begin
                            cpu_rdata_d = cpu_rdata_q;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read data is live during the done cycle and held from the register otherwise.
    assign cpu_rdata = (cpu_done && !we_q) ? mem_rdata : cpu_rdata_q;
    assign ldr_rdata = (ldr_done && !we_q) ? mem_rdata : ldr_rdata_q;
    assign cpu_stall = cpu_req & ~cpu_done;

    // Transaction state and held read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_CPU;
            we_q        <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
            cpu_rdata_q <= {DATA_W{1'b0}};
            ldr_rdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            ldr_rdata_q <= ldr_rdata_d;
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single-port instruction/data memory between the CPU (DataPath/Controller) and the program loader / debug port. Owns the memory control pins. Issues one transaction at a time, tracks the fixed memory read latency, returns read data with a completion pulse, and drives a stall to the CPU Controller while the CPU's access is pending. Sits between `CPU`, the loader and the memory macro.

## Interface

Parameters:
- `ADDR_W`, default 5: memory address width (5-bit operand field of the 8-bit instruction).
- `DATA_W`, default 8: memory word width.
- `MEM_LAT`, default 1, legal range 1..4: cycles from `mem_en` to valid `mem_rdata`.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `cpu_req`, in, 1: CPU access request, held until `cpu_done`.
- `cpu_we`, in, 1: CPU write (1) or read (0).
- `cpu_addr`, in, `ADDR_W`: CPU address.
- `cpu_wdata`, in, `DATA_W`: CPU write data.
- `cpu_gnt`, out, 1: CPU transaction issued this cycle.
- `cpu_done`, out, 1: CPU transaction complete; one-cycle pulse.
- `cpu_rdata`, out, `DATA_W`: read data, valid while `cpu_done` is high.
- `cpu_stall`, out, 1: Controller must hold state.
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata`, `ldr_gnt`, `ldr_done`, `ldr_rdata`: same as the CPU set, for the loader.
- `ldr_lock`, in, 1: loader exclusive mode; the CPU is never granted while this is high.
- `mem_en`, out, 1: memory access strobe.
- `mem_we`, out, 1: memory write enable.
- `mem_addr`, out, `ADDR_W`: memory address.
- `mem_wdata`, out, `DATA_W`: memory write data.
- `mem_rdata`, in, `DATA_W`: memory read data, valid `MEM_LAT` cycles after `mem_en`.

## Operation

- FSM with two states.
  - `IDLE`: at most one grant per cycle. If any eligible request exists, grant the winner and go to `WAIT`.
  - `WAIT`: count `MEM_LAT` cycles, then return to `IDLE`.
- Eligibility: the CPU is eligible when `cpu_req & ~ldr_lock`; the loader is eligible when `ldr_req`.
- Arbitration:
  - Round-robin on a 1-bit `last` pointer.
  - When both requesters are eligible, grant the one not granted last.
  - `last` updates on every grant.
  - Reset value of `last` is loader, so the CPU wins the first contention.
- Issue cycle (IDLE with a grant):
  - `mem_en=1`.
  - `mem_we`, `mem_addr` and `mem_wdata` are taken combinationally from the winner.
  - The winner's `*_gnt=1`.
  - Owner, `we` and a latency counter (width ceil(log2(MEM_LAT+1))) are registered.
- Completion:
  - The owner's `*_done=1` exactly `MEM_LAT` cycles after its grant cycle, for both reads and writes.
  - On reads, `*_rdata` equals `mem_rdata` during the `done` cycle. Outside `done`, `*_rdata` holds its last value.
  - The FSM is in `IDLE` again in the cycle after `done`.
- `cpu_stall = cpu_req & ~cpu_done`. It is combinational and is also high while the CPU is locked out.
- Requests that drop before grant are ignored. A requester must not change `we`/`addr`/`wdata` while waiting.
- `mem_en` is never high in `WAIT`; memory receives exactly one access per transaction.

## Timing

- Reset values: all outputs 0; `state=IDLE`; counter 0; `*_rdata` 0; `last`=loader.
- Grant latency: 0 cycles from request in `IDLE`, i.e. `gnt` in the same cycle as `req`.
- Completion latency: `MEM_LAT` cycles after the grant.
- Back-to-back throughput: one transaction per `MEM_LAT+1` cycles.
- Simultaneous requests: exactly one grant, per the round-robin rule. The loser stays pending and is granted at the next `IDLE` cycle.
- `ldr_lock` rising while a CPU transaction is in `WAIT`: that transaction completes normally. `ldr_lock` is sampled only in `IDLE`.
- `ldr_lock` with no `ldr_req`: no grant is issued, and `cpu_stall` stays high.
- Reset mid-transaction (`rst` high in `WAIT`):
  - Next cycle is `IDLE` with counter 0.
  - The in-flight `done` is suppressed.
  - The memory's late `rdata` is ignored.
- `rst` has priority over all requests in the same cycle: no grant while `rst=1`.

## Structure

- Shared package `mmips_pkg`:
  - `ADDR_W`, `DATA_W` defaults.
  - Owner enum `{OWN_CPU, OWN_LDR}`.
  - State enum `{ST_IDLE, ST_WAIT}`.
- One sub-module is natural: `rr_arb2`. It is a 2-way round-robin picker with `req[1:0]`, `advance`, `gnt[1:0]` and an internal `last` register on `clk`/`rst`.
- The FSM, latency counter, mux and `rdata` registers stay in `mem_arbiter`.

## Test plan

- CPU read only, `MEM_LAT=1`, memory[5]=8'hA7:
  - `cpu_req` `addr=5` at cycle t -> `cpu_gnt` and `mem_en` at t, `cpu_done` at t+1 with `cpu_rdata=8'hA7`, `cpu_stall` high at t only.
- Both requesters read continuously from reset:
  - Grants alternate CPU, LDR, CPU, LDR.
  - Grants land every `MEM_LAT+1` cycles, with no cycle having two grants.
- `ldr_lock=1`, CPU and loader both request:
  - Loader is granted repeatedly and the CPU never is; `cpu_stall` stays 1.
  - Drop lock -> CPU granted at the next `IDLE`.
- `MEM_LAT=3`, loader writes 8'h3C to address 9, then the CPU reads address 9:
  - `ldr_done` 3 cycles after its grant.
  - CPU grant 1 cycle later.
  - `cpu_rdata=8'h3C` 3 cycles after that.
- `rst` asserted 1 cycle after a CPU read grant (`MEM_LAT=2`):
  - No `cpu_done`; all outputs 0 next cycle.
  - A fresh request after reset completes normally.
- Write on the CPU port:
  - `mem_we=1` only in the issue cycle.
  - `cpu_done` pulses after `MEM_LAT` cycles.
  - `cpu_rdata` keeps its previous value.
